// File: rtl/lfsr_rand_pkg.sv
// lfsr_rand_pkg
//   Shared types and constants for the lfsr_rand_gen random source.
//   - state_t      : draw FSM states (IDLE, DIV, HOLD)
//   - tap_mask()   : Fibonacci feedback tap mask for a supported LFSR width
//   - DEFAULT_SEED : power-on LFSR value used when no seed is supplied
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [63:0] DEFAULT_SEED = 64'h1;

  // Tap bits are 0-based positions folded into the feedback XOR.
  // Unsupported widths return an all-zero mask; the top rejects them.
  function automatic logic [63:0] tap_mask(input int width);
    case (width)
      16:      return 64'h0000_0000_0000_D008;  // 15,14,12,3
      32:      return 64'h0000_0000_8020_0003;  // 31,21,1,0
      64:      return 64'hD800_0000_0000_0000;  // 63,62,60,59
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core
//   Free-running Fibonacci LFSR with runtime reseed.
//   Ports:
//     clk       in   clock, all logic on posedge
//     rst_n     in   asynchronous active-low reset, loads RESET_SEED
//     seed_load in   replace the register with seed this cycle
//     seed      in   reseed value (zero is mapped to RESET_SEED)
//     x         out  current LFSR value
module lfsr_core
  import lfsr_rand_pkg::*;
#(
  parameter int                LFSR_W     = 32,
  parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] x
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(tap_mask(LFSR_W));

  logic fb;

  assign fb = ^(x & TAPS);

  // A zero seed would lock the register at zero forever, so it is
  // replaced by RESET_SEED. Reseed takes priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= RESET_SEED;
    end else if (seed_load) begin
      x <= (seed == '0) ? RESET_SEED : seed;
    end else begin
      x <= {x[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen
//   Pseudo-random number source: draws RAW_W low bits of a free-running
//   LFSR on request and reduces them modulo a requested range with a
//   bit-serial restoring divider.
//   Ports:
//     clk, rst_n          clock / asynchronous active-low reset
//     seed_load, seed     runtime reseed of the LFSR
//     req_valid/req_ready request handshake; range sampled on accept
//     out_valid/out_ready result handshake
//     out_data            raw % range (zero when range was 0)
//     range_err           qualifies out_data: the request had range == 0
//   Optional feature: define LFSR_RAND_FASTPATH_EN to answer power-of-two
//   ranges with a mask in one clock instead of the full divide.
module lfsr_rand_gen
  import lfsr_rand_pkg::*;
#(
  parameter int                LFSR_W     = 32,
  parameter int                RAW_W      = 16,
  parameter int                RANGE_W    = 11,
  parameter int                OUT_W      = 11,
  parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_W'(DEFAULT_SEED)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [RANGE_W-1:0] range,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               range_err
);

  localparam int CNT_W = $clog2(RAW_W + 1);

  if (LFSR_W != 16 && LFSR_W != 32 && LFSR_W != 64) begin : g_bad_lfsr_w
    $error("lfsr_rand_gen: LFSR_W must be 16, 32 or 64");
  end
  if (RAW_W > LFSR_W) begin : g_bad_raw_w
    $error("lfsr_rand_gen: RAW_W must not exceed LFSR_W");
  end
  if (OUT_W < RANGE_W) begin : g_bad_out_w
    $error("lfsr_rand_gen: OUT_W must be at least RANGE_W");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_rand_gen: RESET_SEED must be nonzero");
  end

  logic [LFSR_W-1:0]  lfsr_x;
  logic               unused_lfsr;

  state_t             state_q, state_d;
  logic [RAW_W-1:0]   raw_q, raw_d;
  logic [RANGE_W-1:0] range_q, range_d;
  logic [RANGE_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [RANGE_W:0]   rem_shift;

  lfsr_core #(
    .LFSR_W     (LFSR_W),
    .RESET_SEED (RESET_SEED)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .x         (lfsr_x)
  );

  // Only the low RAW_W bits feed a draw; the rest is deliberately unused.
  assign unused_lfsr = ^lfsr_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      raw_q   <= '0;
      range_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      range_q <= range_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The stored remainder is always below range, so RANGE_W bits suffice;
  // only the shifted working value needs the extra bit. cnt holds the
  // number of raw bits still to be consumed; the step that consumes the
  // last one also moves to HOLD, giving RAW_W+1 clocks of latency.
  always_comb begin
    state_d   = state_q;
    raw_d     = raw_q;
    range_d   = range_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rem_shift = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          raw_d   = lfsr_x[RAW_W-1:0];
          range_d = range;
          rem_d   = '0;
          cnt_d   = CNT_W'(RAW_W);
          if (range == '0) begin
            err_d   = 1'b1;
            state_d = HOLD;
          end
`ifdef LFSR_RAND_FASTPATH_EN
          else if ((range & (range - RANGE_W'(1))) == '0) begin
            err_d   = 1'b0;
            rem_d   = RANGE_W'(lfsr_x[RAW_W-1:0]) & (range - RANGE_W'(1));
            state_d = HOLD;
          end
`endif
          else begin
            err_d   = 1'b0;
            state_d = DIV;
          end
        end
      end

      DIV: begin
        rem_shift = {rem_q, raw_q[RAW_W-1]};
        if (rem_shift >= {1'b0, range_q}) begin
          rem_d = RANGE_W'(rem_shift - {1'b0, range_q});
        end else begin
          rem_d = rem_shift[RANGE_W-1:0];
        end
        raw_d = raw_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // req_ready is qualified by rst_n so the block never advertises
  // readiness while it is held in reset.
  always_comb begin
    req_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    range_err = 1'b0;
    if (state_q == IDLE) begin
      req_ready = rst_n;
    end
    if (state_q == HOLD) begin
      out_valid = 1'b1;
      out_data  = OUT_W'(rem_q);
      range_err = err_q;
    end
  end

endmodule
